// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants, types and the double-dabble step used by the display scan
// controller and its binary-to-BCD converter.
package display_scan_ctrl_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned CONV_LEN   = 8;
  localparam int unsigned BIN_W      = 8;
  localparam int unsigned BCD_W      = 12;
  localparam int unsigned ACC_W      = BCD_W + BIN_W;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W      = $clog2(CONV_LEN);

  localparam logic [3:0] BLANK    = 4'hF;
  localparam logic [3:0] AN_UNITS = 4'b1110;
  localparam logic [3:0] AN_TENS  = 4'b1101;
  localparam logic [3:0] AN_HUND  = 4'b1011;
  localparam logic [3:0] AN_SPARE = 4'b0111;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_e;

  typedef struct packed {
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  // One add-3-then-shift step on the {bcd, binary} accumulator.
  function automatic logic [ACC_W-1:0] dd_step(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] a;
    a = acc;
    for (int i = 0; i < 3; i++) begin
      if (a[BIN_W+4*i +: 4] >= 4'd5) a[BIN_W+4*i +: 4] = a[BIN_W+4*i +: 4] + 4'd3;
    end
    return a << 1;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_bin_a_bcd.sv
// Sequential binary-to-BCD converter: the load edge performs the first shift,
// seven more follow, and a one-cycle done state presents the final result.
module bin_a_bcd
  import display_scan_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_e            state, state_nxt;
  logic [ACC_W-1:0]       acc;
  logic [CNT_W-1:0]       cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CONV_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CONV_IDLE:  if (start) state_nxt = CONV_SHIFT;
      CONV_SHIFT: if (cnt == CNT_W'(CONV_LEN - 1)) state_nxt = CONV_DONE;
      CONV_DONE:  state_nxt = CONV_IDLE;
      default:    state_nxt = CONV_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (state != CONV_IDLE) busy = 1'b1;
    if (state == CONV_DONE) done = 1'b1;
  end

  // cnt holds the number of shifts already applied to acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (state == CONV_IDLE && start) begin
      acc <= dd_step({BCD_W'(0), bin});
      cnt <= CNT_W'(1);
    end else if (state == CONV_SHIFT) begin
      acc <= dd_step(acc);
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bcd = acc[ACC_W-1:BIN_W];

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with leading-zero blanking;
// digits come from the bin_a_bcd converter and update atomically.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] numeroBin,
  input  logic       cargar,
  output logic       ocupado,
  output logic [3:0] numeroDCU,
  output logic [3:0] anodos
);

  localparam int unsigned PS_W = $clog2(PRESCALE);

  logic [PS_W-1:0]  presc;
  logic             tick;
  logic [IDX_W-1:0] idx;
  bcd_t             digits;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;

  bin_a_bcd u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (cargar),
    .bin   (numeroBin),
    .busy  (ocupado),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign tick = (presc == PS_W'(PRESCALE - 1));

  // Scan timing and digit registers; the converter never touches the index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      idx    <= '0;
      digits <= '0;
    end else begin
      presc <= tick ? '0 : presc + PS_W'(1);
      if (tick)      idx    <= idx + IDX_W'(1);
      if (conv_done) digits <= bcd_t'(conv_bcd);
    end
  end

  always_comb begin
    anodos    = AN_SPARE;
    numeroDCU = BLANK;
    case (idx)
      2'd0: begin
        anodos    = AN_UNITS;
        numeroDCU = digits.units;
      end
      2'd1: begin
        anodos    = AN_TENS;
        numeroDCU = (digits.hund == 4'd0 && digits.tens == 4'd0) ? BLANK : digits.tens;
      end
      2'd2: begin
        anodos    = AN_HUND;
        numeroDCU = (digits.hund == 4'd0) ? BLANK : digits.hund;
      end
      default: begin
        anodos    = AN_SPARE;
        numeroDCU = BLANK;
      end
    endcase
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: two controllers (PRESCALE 4 and 2) share stimulus and are
// compared every cycle against a decimal-arithmetic model of the display.
module tb_display_scan_ctrl;

  localparam int P_A = 4;
  localparam int P_B = 2;

  typedef struct {
    logic       occ;
    logic [3:0] an;
    logic [3:0] dcu;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] numeroBin;
  logic       cargar;
  logic       ocupado_a, ocupado_b;
  logic [3:0] dcu_a, dcu_b, an_a, an_b;

  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int passed = 0;

  // Model state: edges since reset, cycles left in conversion, shown value.
  int n, rem, disp, pend;

  always #5 clk = ~clk;

  display_scan_ctrl #(.PRESCALE(P_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .numeroBin(numeroBin), .cargar(cargar),
    .ocupado(ocupado_a), .numeroDCU(dcu_a), .anodos(an_a)
  );

  display_scan_ctrl #(.PRESCALE(P_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .numeroBin(numeroBin), .cargar(cargar),
    .ocupado(ocupado_b), .numeroDCU(dcu_b), .anodos(an_b)
  );

  function automatic exp_t expect_for(input int p);
    exp_t e;
    int   slot, h, t, u;
    slot  = (n / p) % 4;
    h     = disp / 100;
    t     = (disp / 10) % 10;
    u     = disp % 10;
    e.occ = (rem > 0);
    case (slot)
      0: begin e.an = 4'b1110; e.dcu = 4'(u); end
      1: begin e.an = 4'b1101; e.dcu = (h == 0 && t == 0) ? 4'hF : 4'(t); end
      2: begin e.an = 4'b1011; e.dcu = (h == 0) ? 4'hF : 4'(h); end
      default: begin e.an = 4'b0111; e.dcu = 4'hF; end
    endcase
    return e;
  endfunction

  task automatic push_expect();
    qa.push_back(expect_for(P_A));
    qb.push_back(expect_for(P_B));
  endtask

  // Effect of one rising edge, using the inputs present at that edge.
  task automatic model_edge();
    if (rem > 0) begin
      rem--;
      if (rem == 0) disp = pend;
    end else if (cargar) begin
      rem  = 8;
      pend = int'(numeroBin);
    end
    n++;
  endtask

  task automatic step(input logic c, input logic [7:0] v);
    @(posedge clk);
    #1;
    model_edge();
    push_expect();
    cargar    = c;
    numeroBin = v;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 8'd0);
  endtask

  task automatic load(input logic [7:0] v);
    step(1'b1, v);
    step(1'b0, 8'd0);
  endtask

  // Short reset pulse entirely between two rising edges.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    cargar    = 1'b0;
    numeroBin = 8'd0;
    n = 0; rem = 0; disp = 0; pend = 0;
    push_expect();
    #5;
    rst_n = 1'b1;
  endtask

  task automatic compare(input int p, input exp_t e, input logic occ,
                         input logic [3:0] an, input logic [3:0] dcu);
    checks++;
    if (occ === e.occ && an === e.an && dcu === e.dcu) passed++;
    else $display("FAIL scan_p%0d t=%0t: got ocupado=%b anodos=%b numeroDCU=%h, want ocupado=%b anodos=%b numeroDCU=%h",
                  p, $time, occ, an, dcu, e.occ, e.an, e.dcu);
  endtask

  always @(negedge clk) begin
    while (qa.size() > 0) compare(P_A, qa.pop_front(), ocupado_a, an_a, dcu_a);
    while (qb.size() > 0) compare(P_B, qb.pop_front(), ocupado_b, an_b, dcu_b);
  end

  initial begin
    rst_n = 1'b0; cargar = 1'b0; numeroBin = 8'd0;
    n = 0; rem = 0; disp = 0; pend = 0;
    do_reset();
    idle(3);

    load(8'd255); idle(26);
    load(8'd7);   idle(26);
    load(8'd0);   idle(26);
    load(8'd105); idle(26);

    // Load attempts on busy cycles 3 and 8 must be ignored.
    load(8'd42);
    step(1'b0, 8'd0);
    step(1'b1, 8'd99);
    step(1'b0, 8'd0); step(1'b0, 8'd0); step(1'b0, 8'd0); step(1'b0, 8'd0);
    step(1'b1, 8'd99);
    step(1'b0, 8'd0);
    idle(20);

    // Reset during busy cycle 4 aborts the conversion.
    load(8'd200);
    idle(2);
    do_reset();
    load(8'd13); idle(26);

    // Completion lands on both tick parities for PRESCALE=2.
    idle(1); load(8'd86); idle(12);
    load(8'd31); idle(12);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else step($urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)));
    end
    idle(2);

    @(negedge clk);
    #1;
    checks++;
    if (qa.size() == 0 && qb.size() == 0) passed++;
    else $display("FAIL drain: got %0d/%0d pending, want 0/0", qa.size(), qb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
